// File: rtl/mem_access_unit.sv
// Data-memory access unit between EX and WB: request/ready handshake to a
// variable-latency memory, pipeline stall while busy, and access fault flags.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_misalign,
    output logic              err_illegal,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} accState;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    accState           state, nextState;
    logic [7:0]        cnt;
    logic              toRegQ;
    logic [DATA_W-1:0] readReg;
    logic              acc, illegal, misalign, start, timeoutHit;

    assign acc        = ex_valid & (MemRead | MemWrite);
    assign illegal    = acc & MemRead & MemWrite;
    assign misalign   = acc & !illegal & (alu_result[1:0] != 2'b00);
    assign start      = acc & !illegal & !misalign;
    // A ready in the final waiting cycle beats the timeout.
    assign timeoutHit = (cnt == LAST_CNT) & !mem_ready;

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        wb_data   = '0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    nextState = BUSY;
                end else if (ex_valid && !acc) begin
                    wb_valid = 1'b1;
                    wb_data  = alu_result;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ready || timeoutHit) nextState = DONE;
            end
            DONE: begin
                wb_valid  = 1'b1;
                wb_data   = toRegQ ? readReg : alu_result;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            toRegQ       <= 1'b0;
            readReg      <= '0;
            err_misalign <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= nextState;
            err_illegal  <= (state == IDLE) & illegal;
            err_misalign <= (state == IDLE) & misalign;
            err_timeout  <= (state == BUSY) & timeoutHit;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= {alu_result[DATA_W-1:2], 2'b00};
                        mem_wdata <= store_data;
                        mem_we    <= MemWrite;
                        toRegQ    <= MemtoReg;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        readReg <= mem_we ? '0 : mem_rdata;
                        mem_we  <= 1'b0;
                        cnt     <= '0;
                    end else if (timeoutHit) begin
                        readReg <= '0;
                        mem_we  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
